// File: rtl/axilite_m00_adder_master.sv
// AXI4-Lite master for the adder slave: start runs write A, write B, read sum,
// read overflow mask, then pulses done with sum/ovf/err. All AXI outputs are registered.
module axilite_m00_adder_master #(
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_AXI_BASEADDR   = '0
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] op_a,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] op_b,
    output logic                          busy,
    output logic                          done,
    output logic [C_M_AXI_DATA_WIDTH-1:0] sum,
    output logic                          ovf,
    output logic                          err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] L_ADDR_A = C_M_AXI_BASEADDR;
    localparam logic [AW-1:0] L_ADDR_B = C_M_AXI_BASEADDR + AW'(4);
    localparam logic [AW-1:0] L_ADDR_S = C_M_AXI_BASEADDR + AW'(8);
    localparam logic [AW-1:0] L_ADDR_O = C_M_AXI_BASEADDR + AW'(12);

    typedef enum logic [2:0] {S_IDLE, S_WR0, S_WR1, S_RD2, S_RD3, S_DONE} state_t;
    state_t r_state, w_next;

    logic          r_busy, r_done, r_ovf, r_err, r_err_pend;
    logic [DW-1:0] r_sum, r_sum_pend, r_op_b, r_wdata;
    logic [AW-1:0] r_awaddr, r_araddr;
    logic          r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic          r_aw_ok, r_w_ok;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_accept, w_in_wr, w_wr_enter, w_rd_enter;

    assign w_aw_hs    = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs     = r_wvalid  & M_AXI_WREADY;
    assign w_b_hs     = r_bready  & M_AXI_BVALID;
    assign w_ar_hs    = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs     = r_rready  & M_AXI_RVALID;
    assign w_accept   = (r_state == S_IDLE) & start;
    assign w_in_wr    = (r_state == S_WR0) | (r_state == S_WR1);
    assign w_wr_enter = (w_next != r_state) & ((w_next == S_WR0) | (w_next == S_WR1));
    assign w_rd_enter = (w_next != r_state) & ((w_next == S_RD2) | (w_next == S_RD3));

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) r_state <= S_IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_WR0;
            S_WR0:   if (w_b_hs) w_next = S_WR1;
            S_WR1:   if (w_b_hs) w_next = S_RD2;
            S_RD2:   if (w_r_hs) w_next = S_RD3;
            S_RD3:   if (w_r_hs) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control, operand capture and results
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_op_b     <= '0;
            r_err_pend <= 1'b0;
            r_sum_pend <= '0;
            r_sum      <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept)               r_busy <= 1'b1;
            else if (r_state == S_DONE) r_busy <= 1'b0;
            r_done <= (r_state == S_RD3) & w_r_hs;
            if (w_accept) r_op_b <= op_b;
            if (w_accept)
                r_err_pend <= 1'b0;
            else if ((w_b_hs & (|M_AXI_BRESP)) | (w_r_hs & (|M_AXI_RRESP)))
                r_err_pend <= 1'b1;
            if (w_r_hs && r_state == S_RD2) r_sum_pend <= M_AXI_RDATA;
            // Results are published on the edge that enters DONE, so they line up with done.
            if (w_r_hs && r_state == S_RD3) begin
                r_sum <= r_sum_pend;
                r_ovf <= |M_AXI_RDATA;
                r_err <= r_err_pend | (|M_AXI_RRESP);
            end
        end
    end

    // Write channels: AW and W retire independently; B is accepted once both have.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_w_ok    <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_bready  <= 1'b0;
        end else begin
            if (w_wr_enter) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_aw_ok   <= 1'b0;
                r_w_ok    <= 1'b0;
                r_awaddr  <= (w_next == S_WR0) ? L_ADDR_A : L_ADDR_B;
                r_wdata   <= (w_next == S_WR0) ? op_a : r_op_b;
            end else begin
                if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                    r_aw_ok   <= 1'b1;
                end
                if (w_w_hs) begin
                    r_wvalid <= 1'b0;
                    r_w_ok   <= 1'b1;
                end
            end
            if (w_b_hs)
                r_bready <= 1'b0;
            else if (w_in_wr && (r_aw_ok | w_aw_hs) && (r_w_ok | w_w_hs))
                r_bready <= 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_rready  <= 1'b0;
        end else begin
            if (w_rd_enter) begin
                r_arvalid <= 1'b1;
                r_araddr  <= (w_next == S_RD2) ? L_ADDR_S : L_ADDR_O;
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end
            if (w_r_hs)       r_rready <= 1'b0;
            else if (w_ar_hs) r_rready <= 1'b1;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign sum           = r_sum;
    assign ovf           = r_ovf;
    assign err           = r_err;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
endmodule

// File: tb/tb_axilite_m00_adder_master.sv
// Bench for the adder AXI-Lite master: behavioural adder slave with configurable
// ready delays and responses, plus a scoreboard for AXI transactions and results.
module tb_axilite_m00_adder_master;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, ovf, err;
    logic [31:0] sum;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    axilite_m00_adder_master #(.C_M_AXI_BASEADDR(BASE)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .sum(sum), .ovf(ovf), .err(err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} tx_t;
    typedef struct {logic [31:0] sum; logic ovf; logic err;} res_t;
    tx_t  exp_tx[$];
    res_t exp_res[$];

    int n_chk = 0, n_pass = 0;
    int aw_delay = 0, w_delay = 0;
    logic [1:0] bresp_wr1 = 2'b00;
    int tx_cnt = 0, done_cnt = 0;
    int prot_err = 0, bready_early = 0, aw_len = 0, w_len = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: event occurred that was not expected", name);
    endtask

    task automatic chk_tx(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        tx_t e;
        if (exp_tx.size() == 0) begin
            fail("tx_unexpected");
            return;
        end
        e = exp_tx.pop_front();
        chk(wr ? "wr_tx" : "rd_tx", {7'b0, wr, addr, data}, {7'b0, e.wr, e.addr, e.data});
    endtask

    // Adder slave: regs[0]=A, regs[1]=B; +8 reads A+B, +12 reads {carry, signed overflow}.
    initial begin : slave
        logic s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, got_aw, got_w;
        logic [31:0] s_awaddr, s_wdata, s_araddr;
        logic [31:0] regs [4];
        logic [32:0] t;
        int aw_c, w_c;
        got_aw = 1'b0; got_w = 1'b0; aw_c = 0; w_c = 0;
        s_awaddr = '0; s_wdata = '0; s_araddr = '0;
        for (int i = 0; i < 4; i++) regs[i] = '0;
        forever begin
            @(negedge clk);
            s_aw_hs = awvalid && awready;
            s_w_hs  = wvalid && wready;
            s_b_hs  = bvalid && bready;
            s_ar_hs = arvalid && arready;
            s_r_hs  = rvalid && rready;
            if (s_aw_hs) begin got_aw = 1'b1; s_awaddr = awaddr; end
            if (s_w_hs)  begin got_w = 1'b1;  s_wdata = wdata;   end
            if (s_ar_hs) s_araddr = araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                got_aw = 0; got_w = 0; aw_c = 0; w_c = 0;
                continue;
            end
            if (s_b_hs) bvalid = 1'b0;
            if (got_aw && got_w && !bvalid) begin
                chk_tx(1'b1, s_awaddr, s_wdata);
                tx_cnt++;
                regs[s_awaddr[3:2]] = s_wdata;
                bresp  = (s_awaddr[3:2] == 2'd1) ? bresp_wr1 : 2'b00;
                bvalid = 1'b1;
                got_aw = 1'b0;
                got_w  = 1'b0;
            end
            if (s_r_hs) rvalid = 1'b0;
            if (s_ar_hs) begin
                chk_tx(1'b0, s_araddr, 32'h0);
                tx_cnt++;
                t = {1'b0, regs[0]} + {1'b0, regs[1]};
                if (s_araddr[3:2] == 2'd2) rdata = t[31:0];
                else rdata = {30'b0, t[32], (regs[0][31] == regs[1][31]) && (t[31] != regs[0][31])};
                rresp  = 2'b00;
                rvalid = 1'b1;
            end
            if (awvalid) begin
                if (aw_c >= aw_delay) awready = 1'b1;
                else begin awready = 1'b0; aw_c++; end
            end else begin awready = 1'b0; aw_c = 0; end
            if (wvalid) begin
                if (w_c >= w_delay) wready = 1'b1;
                else begin wready = 1'b0; w_c++; end
            end else begin wready = 1'b0; w_c = 0; end
            arready = arvalid;
        end
    end

    // Monitor: result scoreboard and handshake-protocol observation.
    initial begin : monitor
        logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, aw_seen, w_seen;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        int aw_run, w_run;
        res_t e;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        aw_seen = 0; w_seen = 0; aw_run = 0; w_run = 0;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_awv = 0; p_wv = 0; p_arv = 0; aw_seen = 0; w_seen = 0; aw_run = 0; w_run = 0;
                continue;
            end
            if (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) prot_err++;
            if (p_wv && !p_wr && (!wvalid || wdata != p_wdata)) prot_err++;
            if (p_arv && !p_arr && (!arvalid || araddr != p_araddr)) prot_err++;
            if (bready && !(aw_seen && w_seen)) bready_early++;
            if (awvalid) aw_run++;
            if (wvalid) w_run++;
            if (awvalid && awready) begin aw_seen = 1; aw_len = aw_run; aw_run = 0; end
            if (wvalid && wready) begin w_seen = 1; w_len = w_run; w_run = 0; end
            if (bvalid && bready) begin aw_seen = 0; w_seen = 0; end
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            if (done) begin
                done_cnt++;
                if (exp_res.size() == 0) fail("done_unexpected");
                else begin
                    e = exp_res.pop_front();
                    chk("result_sum_ovf_err", {38'b0, sum, ovf, err}, {38'b0, e.sum, e.ovf, e.err});
                    chk("busy_at_done", busy, 1'b1);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, b, s, input logic o, e);
        exp_res.push_back('{s, o, e});
        exp_tx.push_back('{1'b1, BASE, a});
        exp_tx.push_back('{1'b1, BASE + 32'd4, b});
        exp_tx.push_back('{1'b0, BASE + 32'd8, 32'h0});
        exp_tx.push_back('{1'b0, BASE + 32'd12, 32'h0});
    endtask

    task automatic run(input logic [31:0] a, b, s, input logic o, e, input bit repulse, output int cyc);
        push_exp(a, b, s, o, e);
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; op_a = ~a; op_b = ~b;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (repulse && cyc == 3) begin start = 1'b1; op_a = 32'hDEAD; op_b = 32'hBEEF; end
            else start = 1'b0;
        end
        if (!done) fail("done_timeout");
        @(posedge clk); #1;
        chk("busy_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc, dc, tc, k;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {busy, done, ovf, err, awvalid, wvalid, bready, arvalid, rready}, 9'b0);
        chk("reset_sum_wdata", {sum, wdata}, 64'h0);
        @(negedge clk) rst_n = 1'b1;

        run(32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0, cyc);
        chk("latency_start_to_done", cyc, 9);
        run(32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, cyc);
        run(32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, cyc);

        aw_delay = 3;
        run(32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1'b0, cyc);
        aw_delay = 0;
        chk("awvalid_cycles_delayed", aw_len, 4);
        chk("wvalid_cycles", w_len, 1);
        chk("bready_before_aw_w", bready_early, 0);

        bresp_wr1 = 2'b10;
        run(32'd100, 32'd200, 32'd300, 1'b0, 1'b1, 1'b0, cyc);
        bresp_wr1 = 2'b00;
        run(32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b0, 1'b0, cyc);

        dc = done_cnt; tc = tx_cnt;
        run(32'd7, 32'd9, 32'd16, 1'b0, 1'b0, 1'b1, cyc);
        repeat (6) @(posedge clk);
        chk("repulse_tx_count", tx_cnt - tc, 4);
        chk("repulse_done_count", done_cnt - dc, 1);

        // Abort with reset while the sum read address is outstanding.
        push_exp(32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; op_a = 32'd1; op_b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(arvalid && araddr == BASE + 32'd8) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100) fail("rd2_timeout");
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_flags", {busy, done, ovf, err, awvalid, wvalid, bready, arvalid, rready}, 9'b0);
        chk("midrst_sum", sum, 32'h0);
        chk("midrst_addr", {awaddr, araddr}, 64'h0);
        exp_tx.delete();
        exp_res.delete();
        dc = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("midrst_no_done", done_cnt - dc, 0);
        run(32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0, cyc);

        repeat (4) @(posedge clk);
        chk("valid_stability", prot_err, 0);
        chk("bready_total_early", bready_early, 0);
        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("res_queue_drained", exp_res.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
